sync_tgl_evt_rx: RTL
====================

// Module: sync_tgl_evt_rx
// PURPOSE
//  Receive-side event endpoint placed directly downstream of a 3-flop
//  synchronizer (sync3d_c_ppp q output). Turns edges of the synchronized
//  toggle/level into counted events and queues them in a saturating pending
//  counter. Presents the events on a valid/ready interface and returns an ack
//  toggle per consumed event, to be synchronized back to the source domain.
// PARAMETERS
//  CNT_W      4  width of pending-event counter; max pending = 2^CNT_W-1
//  EDGE_MODE  0  0: every transition of d_sync is an event (toggle protocol)
//                1: only rising transitions are events (pulse-stretch protocol)
// PORTS
//  clk       in   1      core clock (same clock as the upstream synchronizer)
//  rst       in   1      asynchronous reset, active-high
//  en        in   1      event capture enable
//  d_sync    in   1      synchronized input (q of the 3-flop synchronizer)
//  evt_valid out  1      at least one event pending
//  evt_ready in   1      consumer accepts one event when evt_valid=1
//  evt_pend  out  CNT_W  current pending-event count
//  ack_tgl   out  1      toggles once per consumed event
//  ovf       out  1      sticky: an event was dropped due to saturation
//  ovf_clr   in   1      clears ovf
// BEHAVIOUR
//  - Reset (async assert, sync release): d_prev=0, evt_pend=0, evt_valid=0,
//    ack_tgl=0, ovf=0. d_prev reset value 0 matches the synchronizer clear.
//  - d_prev <= d_sync every cycle, independent of en.
//  - edge = en & (EDGE_MODE==0 ? d_sync^d_prev : d_sync&~d_prev).
//    Edges while en=0 are discarded, never deferred.
//  - pop = evt_valid & evt_ready. evt_ready while evt_valid=0 has no effect.
//  - Counter update, per cycle:
//      edge & !pop -> +1 (if not saturated); !edge & pop -> -1;
//      edge & pop -> unchanged; neither -> unchanged.
//  - Saturation: edge & !pop & evt_pend==max -> count holds, event dropped,
//    ovf<=1. edge & pop at max -> no drop, no ovf.
//  - evt_valid = (evt_pend != 0), decoded from the registered count only.
//    No combinational path from evt_ready to evt_valid.
//  - Latency: d_sync changes in cycle N -> evt_pend increments at end of N ->
//    evt_valid=1 in cycle N+1. Back-to-back pops drain one event per cycle.
//  - ack_tgl <= ack_tgl ^ pop (registered). It toggles in the cycle after the pop.
//  - ovf: set wins over ovf_clr when both occur in the same cycle.
//  - Reset mid-operation discards all pending events and returns ack_tgl to 0.
//    The source-side toggle must be reset in the same reset domain.
//  - Two edges closer than 1 cycle apart cannot occur at d_sync. Each cycle
//    yields at most one event.
// TESTING
//  1 Reset: assert rst mid-queue with evt_pend=3 -> all outputs 0
//    asynchronously. Hold 0 after release until the next edge.
//  2 Toggle mode: d_sync 0->1 at cycle 10 with evt_ready=0 -> evt_valid=1 at
//    cycle 11, evt_pend=1. Raise evt_ready at cycle 13 -> evt_pend=0 and
//    ack_tgl=1 at cycle 14.
//  3 Burst: toggle d_sync every cycle for 5 cycles, evt_ready=0 -> evt_pend=5.
//    Then evt_ready=1 -> five consecutive pops, ack_tgl ends at 1.
//  4 Saturation (CNT_W=4): 16 toggles with no pops -> evt_pend=15, ovf=1.
//    At evt_pend=15, edge plus pop in the same cycle -> evt_pend=15, no new ovf.
//    ovf_clr together with a drop -> ovf stays 1.
//  5 EDGE_MODE=1: d_sync 0->1->0->1 -> evt_pend=2. With en=0 during a rising
//    edge -> no increment, and that edge is not recovered when en returns to 1.
//  6 Simultaneous: evt_pend=2 with edge and pop in the same cycle -> evt_pend=2,
//    ack_tgl toggles once. Random edge/ready/en streams checked against a
//    reference counter model.

Source files
------------

// File: rtl/sync_tgl_evt_rx.sv
// Receive-side event endpoint behind a 3-flop synchronizer: converts edges of the
// synchronized toggle/level into queued events with valid/ready pop and ack toggle return.
module sync_tgl_evt_rx #(
   parameter int CNT_W     = 4,
   parameter bit EDGE_MODE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             d_sync,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [CNT_W-1:0] evt_pend,
   output logic             ack_tgl,
   output logic             ovf,
   input  logic             ovf_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   logic             d_prev_r;
   logic [CNT_W-1:0] cnt_r;
   logic             valid_r;
   logic             ack_r;
   logic             ovf_r;

   logic             edge_s;
   logic             pop_s;
   logic             drop_s;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             ovf_nxt_s;

   // Event detection, pop qualification and pending-count next state
   always_comb begin
      edge_s    = 1'b0;
      drop_s    = 1'b0;
      cnt_nxt_s = cnt_r;
      ovf_nxt_s = ovf_r;

      if (EDGE_MODE) begin
         edge_s = en & d_sync & ~d_prev_r;
      end else begin
         edge_s = en & (d_sync ^ d_prev_r);
      end

      // pop only looks at the registered valid, so ready never reaches valid combinationally
      pop_s = valid_r & evt_ready;

      case ({edge_s, pop_s})
         2'b10: begin
            if (cnt_r == CNT_MAX) begin
               drop_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
         default: cnt_nxt_s = cnt_r;
      endcase

      // a drop in the same cycle as a clear keeps the flag set
      if (drop_s) begin
         ovf_nxt_s = 1'b1;
      end else if (ovf_clr) begin
         ovf_nxt_s = 1'b0;
      end else begin
         ovf_nxt_s = ovf_r;
      end
   end

   // State registers; d_prev follows d_sync every cycle regardless of en
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_prev_r <= 1'b0;
         cnt_r    <= CNT_ZERO;
         valid_r  <= 1'b0;
         ack_r    <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         d_prev_r <= d_sync;
         cnt_r    <= cnt_nxt_s;
         valid_r  <= (cnt_nxt_s != CNT_ZERO);
         ack_r    <= ack_r ^ pop_s;
         ovf_r    <= ovf_nxt_s;
      end
   end

   assign evt_valid = valid_r;
   assign evt_pend  = cnt_r;
   assign ack_tgl   = ack_r;
   assign ovf       = ovf_r;

endmodule
